vdp_irq_unit: RTL and testbench
===============================

# vdp_irq_unit

Parametrised VDP interrupt and V-counter unit. It replaces the single-state frame-interrupt FSM and the free-standing status flops with one block. The block provides:
- a reloading line-interrupt down-counter;
- a frame-interrupt flag;
- sticky sprite-event flags;
- clear-on-read status semantics;
- a registered, remapped V counter for the CPU-readable 0x7E port.

It sits between the VGA timing generator / register file and the CPU port decoder in `vdp_top`.

## Interface
Parameters:
- `CNT_W`, 8: width of the line counter and of `line_reload`.
- `ACTIVE_LINES`, 192: number of active display lines. Lines are numbered 0..ACTIVE_LINES-1.
- `TOTAL_LINES`, 262: scanlines per frame. Any `line_num` ≥ TOTAL_LINES is ignored.
- `VJUMP`, 218: last scanline reported unmodified on `vcount`.
- `VJUMP_OFS`, 6: amount subtracted from `line_num` above `VJUMP`.

Ports:
- `clk` in 1: block clock (VGA domain).
- `rst_L` in 1: reset, asynchronous, active-low.
- `line_start` in 1: one-cycle pulse at the start of each scanline.
- `line_num` in 9: current scanline index. Sampled only when `line_start`=1.
- `line_ie` in 1: line interrupt enable (reg0 bit 4).
- `frame_ie` in 1: frame interrupt enable (reg1 bit 5).
- `line_reload` in CNT_W: line counter reload value (reg10).
- `ext_set` in 2: event pulses. Bit 1 = sprite overflow, bit 0 = sprite collision.
- `stat_rd` in 1: one-cycle pulse when the CPU reads the control port.
- `status` out 8: {frame_flag, ovfw_flag, coll_flag, 5'b0}.
- `INT_L` out 1: active-low interrupt request to the CPU.
- `vcount` out 8: registered V counter.
- `line_cnt` out CNT_W: current line counter value (debug).

## Operation
All actions below occur on a clock edge where `line_start`=1 and `line_num` < TOTAL_LINES, unless stated otherwise.

- **Line counter, active region** (`line_num` ≤ ACTIVE_LINES, so one line past the end is included):
  - If `line_cnt`==0: `line_cnt` ← `line_reload` and `line_flag` ← 1.
  - Otherwise: `line_cnt` ← `line_cnt`−1.
- **Line counter, outside active region** (`line_num` > ACTIVE_LINES): `line_cnt` ← `line_reload` every line. No flag is set.
- **Frame flag:** `frame_flag` ← 1 when `line_num` == ACTIVE_LINES+1.
- **Sprite flags:** `ext_set[i]`=1 sets the corresponding sticky flag on any cycle, independent of `line_start`.
- **Status read:** `stat_rd`=1 clears `frame_flag`, `line_flag`, `ovfw_flag` and `coll_flag` on that edge. `status` is combinational from the flags, so the CPU sees the pre-clear value during the read.
- **Set/clear collision:** if a set event and `stat_rd` occur on the same edge, set wins and the flag remains 1. No event is lost.
- **Interrupt output:** `INT_L` = ~((`frame_flag` & `frame_ie`) | (`line_flag` & `line_ie`)).
  - Deasserting an enable does not clear its flag.
  - Re-enabling while the flag is pending reasserts `INT_L` combinationally.
- **V counter:** `vcount` ← `line_num`[7:0] if `line_num` ≤ VJUMP, else (`line_num` − VJUMP_OFS)[7:0]. Updated only on `line_start`.
- `line_flag` is internal; it is not visible in `status`.

## Timing
- **Reset values:**
  - `status`=8'h00, `INT_L`=1, `vcount`=0, `line_cnt`=0.
  - All flags are 0.
  - Reset mid-frame clears everything immediately (asynchronous).
  - Counting resumes on the next `line_start`. With `line_cnt`=0, the first active-region `line_start` after reset reloads the counter and sets `line_flag`.
- **Latency:**
  - Flags, `line_cnt` and `vcount` update one edge after the qualifying `line_start`/`ext_set` pulse.
  - `INT_L` follows the flags combinationally, so it falls in the cycle after the event edge.
- **Wrap-around:** `line_cnt` never underflows; it reloads at 0. With `line_reload`=0, `line_flag` sets on every active-region line.
- **Reload value changes:** a new `line_reload` takes effect at the next reload, not mid-count.
- **Invalid line numbers:** a `line_start` with `line_num` ≥ TOTAL_LINES is a no-op for every register.
- **Back-to-back reads:** consecutive `stat_rd` pulses are legal. The second read returns 0 unless a set occurred in between.

## Configuration
- `VDP_IRQ_SPRITE_FLAGS_EN` defined:
  - `ext_set` is honoured.
  - `status`[6:5] reflect `ovfw_flag` and `coll_flag`.
  - Both flags clear on `stat_rd`.
- Not defined:
  - `ovfw_flag` and `coll_flag` are not instantiated.
  - `status`[6:5] = 0 and `ext_set` is ignored.
  - All other behaviour is identical.

## Test plan
- **Line interrupt period:** `line_reload`=3, `line_ie`=1, `line_start` for lines 0..10.
  - `line_flag` sets after lines 0 (reset value 0) and 4.
  - `INT_L`=0 from the cycle after line 0.
  - Issue `stat_rd` after line 2: `INT_L` returns to 1 and reasserts after line 4.
- **Frame interrupt:** `frame_ie`=1, `line_start` at `line_num`=193.
  - `status`=8'h80 and `INT_L`=0 on the next cycle.
  - `stat_rd` returns 8'h80, then `status`=8'h00 and `INT_L`=1.
- **Blank-region reload:** `line_reload`=5, pulse lines 193..200.
  - `line_cnt`==5 after each pulse.
  - No line interrupt is raised.
- **Set/clear collision:** `ext_set`=2'b10 and `stat_rd` on the same edge.
  - `status`=8'h40 afterwards.
  - Without the macro, `status`=8'h00.
- **V counter remap:** `line_num`=218 gives `vcount`=8'hDA; 219 gives 8'hD5; 261 gives 8'hFF; 0 gives 8'h00.
- **Mid-frame reset:** assert `rst_L`=0 with `frame_flag`=1 and `line_cnt`=2.
  - `status`, `line_cnt` and `vcount` read 0 and `INT_L`=1 in the same cycle.

Source files
------------

// File: rtl/vdp_irq_unit.sv
// ---------------------------------------------------------------------------
// vdp_irq_unit
//
// VDP interrupt and V-counter unit. It combines:
//   - the reloading line-interrupt down-counter,
//   - the frame-interrupt flag,
//   - sticky sprite-event flags,
//   - clear-on-read status semantics,
//   - the registered, remapped V counter for the CPU 0x7E port.
//
// Optional feature macro: VDP_IRQ_SPRITE_FLAGS_EN
//   defined   : ext_set sets sticky ovfw/coll flags, shown in status[6:5]
//               and cleared by stat_rd.
//   undefined : no sprite flags exist, status[6:5] = 0, ext_set is ignored.
//
// Ports:
//   clk          in   block clock (VGA domain)
//   rst_L        in   asynchronous active-low reset
//   line_start   in   one-cycle pulse at the start of each scanline
//   line_num     in   [8:0] scanline index, sampled only with line_start
//   line_ie      in   line interrupt enable
//   frame_ie     in   frame interrupt enable
//   line_reload  in   [CNT_W-1:0] line counter reload value
//   ext_set      in   [1:0] event pulses (1 = sprite overflow, 0 = collision)
//   stat_rd      in   one-cycle pulse on a CPU control-port read
//   status       out  [7:0] {frame_flag, ovfw_flag, coll_flag, 5'b0}
//   INT_L        out  active-low interrupt request
//   vcount       out  [7:0] registered, remapped V counter
//   line_cnt     out  [CNT_W-1:0] current line counter value (debug)
// ---------------------------------------------------------------------------
module vdp_irq_unit #(
    parameter int CNT_W        = 8,
    parameter int ACTIVE_LINES = 192,
    parameter int TOTAL_LINES  = 262,
    parameter int VJUMP        = 218,
    parameter int VJUMP_OFS    = 6
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             line_start,
    input  logic [8:0]       line_num,
    input  logic             line_ie,
    input  logic             frame_ie,
    input  logic [CNT_W-1:0] line_reload,
    input  logic [1:0]       ext_set,
    input  logic             stat_rd,
    output logic [7:0]       status,
    output logic             INT_L,
    output logic [7:0]       vcount,
    output logic [CNT_W-1:0] line_cnt
);

    // Line-number constants sized to line_num so every compare is 9 bits.
    localparam logic [8:0] TOTAL_L     = 9'(TOTAL_LINES);
    localparam logic [8:0] ACTIVE_L    = 9'(ACTIVE_LINES);
    localparam logic [8:0] FRAME_LINE  = 9'(ACTIVE_LINES + 1);
    localparam logic [8:0] VJUMP_L     = 9'(VJUMP);
    localparam logic [8:0] VJUMP_OFS_L = 9'(VJUMP_OFS);

    // A line_start with an out-of-range line number is ignored entirely.
    logic line_valid;
    logic in_active;
    logic cnt_zero;
    logic line_set;
    logic frame_set;
    logic [7:0] vcount_next;

    logic line_flag;
    logic frame_flag;
    logic [1:0] sprite_bits;

    assign line_valid = line_start && (line_num < TOTAL_L);
    // Active region includes one line past the last displayed line.
    assign in_active  = (line_num <= ACTIVE_L);
    assign cnt_zero   = (line_cnt == '0);
    assign line_set   = line_valid && in_active && cnt_zero;
    assign frame_set  = line_valid && (line_num == FRAME_LINE);

    // Lines above VJUMP are folded back so the 8-bit counter wraps the way
    // the CPU software expects.
    always_comb begin
        vcount_next = line_num[7:0];
        if (line_num > VJUMP_L) begin
            vcount_next = 8'(line_num - VJUMP_OFS_L);
        end
    end

    // Line counter: reloads at 0 (never underflows) inside the active
    // region and is held at the reload value throughout blanking.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            line_cnt <= '0;
        end else if (line_valid) begin
            if (!in_active || cnt_zero) begin
                line_cnt <= line_reload;
            end else begin
                line_cnt <= line_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            vcount <= 8'h00;
        end else if (line_valid) begin
            vcount <= vcount_next;
        end
    end

    // Flags: a set on the same edge as a status read wins, so no event
    // is lost between the CPU's read and the clear.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            line_flag <= 1'b0;
        end else if (line_set) begin
            line_flag <= 1'b1;
        end else if (stat_rd) begin
            line_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            frame_flag <= 1'b0;
        end else if (frame_set) begin
            frame_flag <= 1'b1;
        end else if (stat_rd) begin
            frame_flag <= 1'b0;
        end
    end

`ifdef VDP_IRQ_SPRITE_FLAGS_EN
    logic ovfw_flag;
    logic coll_flag;

    // Sprite events are sticky and independent of line_start.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            ovfw_flag <= 1'b0;
        end else if (ext_set[1]) begin
            ovfw_flag <= 1'b1;
        end else if (stat_rd) begin
            ovfw_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            coll_flag <= 1'b0;
        end else if (ext_set[0]) begin
            coll_flag <= 1'b1;
        end else if (stat_rd) begin
            coll_flag <= 1'b0;
        end
    end

    assign sprite_bits = {ovfw_flag, coll_flag};
`else
    // Sprite flags are not built; the event inputs are intentionally dropped.
    logic unused_ext_set;
    assign unused_ext_set = ^ext_set;
    assign sprite_bits    = 2'b00;
`endif

    // Status is combinational so the CPU sees the pre-clear value during
    // the read cycle. line_flag is deliberately not exposed here.
    assign status = {frame_flag, sprite_bits, 5'b00000};

    // Enables only gate the request; flags stay pending while disabled.
    assign INT_L = ~((frame_flag & frame_ie) | (line_flag & line_ie));

endmodule

// File: tb/tb_vdp_irq_unit.sv
// ---------------------------------------------------------------------------
// tb_vdp_irq_unit
//
// Self-checking bench for vdp_irq_unit. Inputs are driven on the falling
// edge, outputs are compared against a behavioural model before each rising
// edge, and the model advances on the rising edge from the scanline rules.
// Honours VDP_IRQ_SPRITE_FLAGS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_vdp_irq_unit;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_L = 1'b0;
    logic       line_start = 1'b0;
    logic [8:0] line_num = 9'd0;
    logic       line_ie = 1'b0;
    logic       frame_ie = 1'b0;
    logic [7:0] line_reload = 8'd0;
    logic [1:0] ext_set = 2'b00;
    logic       stat_rd = 1'b0;
    logic [7:0] status;
    logic       INT_L;
    logic [7:0] vcount;
    logic [7:0] line_cnt;

    always #5 clk = ~clk;

    vdp_irq_unit dut (
        .clk         (clk),
        .rst_L       (rst_L),
        .line_start  (line_start),
        .line_num    (line_num),
        .line_ie     (line_ie),
        .frame_ie    (frame_ie),
        .line_reload (line_reload),
        .ext_set     (ext_set),
        .stat_rd     (stat_rd),
        .status      (status),
        .INT_L       (INT_L),
        .vcount      (vcount),
        .line_cnt    (line_cnt)
    );

    // ---------------- scoreboard / counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks what the scanline rules say the block should hold.
    int m_cnt;
    int m_vcount;
    bit m_line;
    bit m_frame;
    bit m_ovfw;
    bit m_coll;

    function automatic void model_reset();
        m_cnt = 0; m_vcount = 0;
        m_line = 0; m_frame = 0; m_ovfw = 0; m_coll = 0;
    endfunction

    function automatic logic [7:0] exp_status();
        return {m_frame, m_ovfw, m_coll, 5'b00000};
    endfunction

    function automatic logic exp_int_l();
        return !((m_frame && frame_ie) || (m_line && line_ie));
    endfunction

    function automatic void model_step(input bit ls, input int ln, input bit [1:0] es, input bit rd);
        bit lset = 0;
        bit fset = 0;
        if (ls && ln < 262) begin
            if (ln <= 192) begin
                if (m_cnt == 0) begin
                    m_cnt = int'(line_reload);
                    lset = 1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else begin
                m_cnt = int'(line_reload);
            end
            fset = (ln == 193);
            m_vcount = ((ln <= 218) ? ln : ln - 6) % 256;
        end
        m_line  = lset ? 1'b1 : (rd ? 1'b0 : m_line);
        m_frame = fset ? 1'b1 : (rd ? 1'b0 : m_frame);
`ifdef VDP_IRQ_SPRITE_FLAGS_EN
        m_ovfw = es[1] ? 1'b1 : (rd ? 1'b0 : m_ovfw);
        m_coll = es[0] ? 1'b1 : (rd ? 1'b0 : m_coll);
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: drive on the falling edge, compare, advance model on the
    // rising edge, then return inputs to idle just after the edge.
    task automatic cycle(input bit ls, input int ln, input bit [1:0] es, input bit rd);
        @(negedge clk);
        line_start = ls;
        line_num   = 9'(ln);
        ext_set    = es;
        stat_rd    = rd;
        #1;
        check("status",   32'(status),   32'(exp_status()));
        check("int_l",    32'(INT_L),    32'(exp_int_l()));
        check("vcount",   32'(vcount),   32'(m_vcount));
        check("line_cnt", 32'(line_cnt), 32'(m_cnt));
        @(posedge clk);
        model_step(ls, ln, es, rd);
        #1;
        line_start = 1'b0;
        ext_set    = 2'b00;
        stat_rd    = 1'b0;
    endtask

    // Scanline pulse followed by one idle cycle.
    task automatic line(input int ln);
        cycle(1'b1, ln, 2'b00, 1'b0);
        cycle(1'b0, 0, 2'b00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_L = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_L = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ln_seq;
        model_reset();
        do_reset();

        // Reset state.
        #1;
        check("rst_status",   32'(status),   32'h00);
        check("rst_int_l",    32'(INT_L),    32'h1);
        check("rst_vcount",   32'(vcount),   32'h00);
        check("rst_line_cnt", 32'(line_cnt), 32'h00);

        // Line interrupt period: reload 3, flag after lines 0 and 4.
        line_reload = 8'd3; line_ie = 1'b1; frame_ie = 1'b0;
        line(0);
        check("lirq_after_l0", 32'(INT_L), 32'h0);
        check("lcnt_after_l0", 32'(line_cnt), 32'd3);
        line(1);
        line(2);
        cycle(1'b0, 0, 2'b00, 1'b1);
        check("lirq_cleared", 32'(INT_L), 32'h1);
        line(3);
        check("lirq_l3_quiet", 32'(INT_L), 32'h1);
        line(4);
        check("lirq_after_l4", 32'(INT_L), 32'h0);
        // Disable hides the request, re-enable brings it back.
        line_ie = 1'b0;
        cycle(1'b0, 0, 2'b00, 1'b0);
        check("lirq_masked", 32'(INT_L), 32'h1);
        line_ie = 1'b1;
        #1;
        check("lirq_reenable", 32'(INT_L), 32'h0);
        for (int l = 5; l <= 10; l++) line(l);

        // Frame interrupt.
        do_reset();
        frame_ie = 1'b1; line_ie = 1'b0;
        line(193);
        check("frame_status", 32'(status), 32'h80);
        check("frame_int_l",  32'(INT_L),  32'h0);
        cycle(1'b0, 0, 2'b00, 1'b1);
        check("frame_clr_status", 32'(status), 32'h00);
        check("frame_clr_int_l",  32'(INT_L),  32'h1);
        // Back-to-back read with nothing set in between.
        cycle(1'b0, 0, 2'b00, 1'b1);
        check("frame_reread", 32'(status), 32'h00);

        // Blank-region reload.
        do_reset();
        line_reload = 8'd5; line_ie = 1'b1; frame_ie = 1'b0;
        for (int l = 193; l <= 200; l++) begin
            line(l);
            check("blank_reload", 32'(line_cnt), 32'd5);
            check("blank_no_irq", 32'(INT_L), 32'h1);
        end

        // Set/clear collision.
        do_reset();
        cycle(1'b0, 0, 2'b10, 1'b1);
`ifdef VDP_IRQ_SPRITE_FLAGS_EN
        check("set_wins", 32'(status), 32'h40);
`else
        check("set_wins", 32'(status), 32'h00);
`endif

        // V counter remap.
        line(218); check("vc_218", 32'(vcount), 32'hDA);
        line(219); check("vc_219", 32'(vcount), 32'hD5);
        line(261); check("vc_261", 32'(vcount), 32'hFF);
        line(262); check("vc_262_ignored", 32'(vcount), 32'hFF);
        line(0);   check("vc_0",   32'(vcount), 32'h00);

        // Mid-frame reset with frame_flag=1 and line_cnt=2.
        do_reset();
        line_reload = 8'd3; frame_ie = 1'b1; line_ie = 1'b0;
        line(193);
        line(0);
        check("pre_rst_cnt",    32'(line_cnt), 32'd2);
        check("pre_rst_status", 32'(status),   32'h80);
        @(negedge clk);
        rst_L = 1'b0;
        #1;
        check("mid_rst_status", 32'(status),   32'h00);
        check("mid_rst_cnt",    32'(line_cnt), 32'h00);
        check("mid_rst_vcount", 32'(vcount),   32'h00);
        check("mid_rst_int_l",  32'(INT_L),    32'h1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_L = 1'b1;

        // Randomized run: mostly sequential scanlines, occasional random or
        // out-of-range numbers, random reads, events and enable changes.
        ln_seq = 0;
        for (int i = 0; i < 3000; i++) begin
            bit ls;
            bit rd;
            bit [1:0] es;
            int ln;
            ls = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 4) == 0);
            es = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 15) == 0) line_ie = ~line_ie;
            if ($urandom_range(0, 15) == 0) frame_ie = ~frame_ie;
            if ($urandom_range(0, 31) == 0) begin
                line_reload = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                          : 8'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 15) == 0) begin
                ln = $urandom_range(0, 511);
            end else begin
                ln = ln_seq;
                if (ls) ln_seq = (ln_seq + 1) % 262;
            end
            cycle(ls, ln, es, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
